bin2bcd_seq: RTL

Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter for the 4-digit seven-segment display path. It accepts a binary value on a start pulse and converts it over BIN_W clock cycles. It presents four BCD digits plus a saturation flag, and pulses done when the result updates. It sits between the reaction-timer control FSM, which produces the millisecond count, and the per-digit seven-segment decoders.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bin2bcd_seq_if.sv | 24 ++
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OP   = 1'b1
  } state_e;

  localparam int unsigned INT_DIGITS = 5;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned ACC_W      = INT_DIGITS * DIGIT_W;
  localparam int unsigned BCD_MAX    = 9999;
  localparam logic [3:0]  SAT_DIGIT  = 4'd9;

  // Decimal value of four packed BCD digits (thousands in the top nibble).
  function automatic int unsigned bcd4_value(input logic [15:0] d);
    return 32'(d[15:12]) * 32'd1000 + 32'(d[11:8]) * 32'd100 +
           32'(d[7:4]) * 32'd10 + 32'(d[3:0]);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/result bus between the timer control FSM and the BCD converter.
interface bin2bcd_seq_if #(
  parameter int unsigned BIN_W = 16
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             ready;
  logic             done_tick;
  logic [3:0]       bcd3;
  logic [3:0]       bcd2;
  logic [3:0]       bcd1;
  logic [3:0]       bcd0;
  logic             overflow;

  modport master (
    output start, bin_in,
    input  ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow
  );

  modport slave (
    input  start, bin_in,
    output ready, done_tick, bcd3, bcd2, bcd1, bcd0, overflow
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  // Input never exceeds 9, so the 4-bit add cannot wrap.
  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: BIN_W cycles per value, 4 saturating BCD digits out.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_e            state_q;
  logic [BIN_W-1:0]  shift_q;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              done_q;
  logic [3:0]        bcd3_q;
  logic [3:0]        bcd2_q;
  logic [3:0]        bcd1_q;
  logic [3:0]        bcd0_q;
  logic              ovf_q;

  logic [ACC_W-1:0]  acc_adj_c;
  logic [ACC_W-1:0]  acc_shift_c;
  logic [BIN_W-1:0]  shift_next_c;
  logic              sat_c;

  // One add-3 cell per internal digit, applied before each shift.
  for (genvar i = 0; i < INT_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[i*DIGIT_W +: DIGIT_W]),
      .digit_o (acc_adj_c[i*DIGIT_W +: DIGIT_W])
    );
  end

  // {acc, shift} shifted left by one after correction.
  assign acc_shift_c  = {acc_adj_c[ACC_W-2:0], shift_q[BIN_W-1]};
  assign shift_next_c = {shift_q[BIN_W-2:0], 1'b0};

  // Anything in the ten-thousands digit, or a lower-four value above 9999, saturates.
  assign sat_c = (acc_shift_c[ACC_W-1 -: DIGIT_W] != 4'd0) ||
                 (bcd4_value(acc_shift_c[15:0]) > BCD_MAX);

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      bcd3_q  <= 4'd0;
      bcd2_q  <= 4'd0;
      bcd1_q  <= 4'd0;
      bcd0_q  <= 4'd0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            shift_q <= bus.bin_in;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            ready_q <= 1'b0;
            state_q <= S_OP;
          end
        end
        S_OP: begin
          acc_q   <= acc_shift_c;
          shift_q <= shift_next_c;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            ovf_q   <= sat_c;
            if (sat_c) begin
              bcd3_q <= SAT_DIGIT;
              bcd2_q <= SAT_DIGIT;
              bcd1_q <= SAT_DIGIT;
              bcd0_q <= SAT_DIGIT;
            end else begin
              bcd3_q <= acc_shift_c[15:12];
              bcd2_q <= acc_shift_c[11:8];
              bcd1_q <= acc_shift_c[7:4];
              bcd0_q <= acc_shift_c[3:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.bcd3      = bcd3_q;
  assign bus.bcd2      = bcd2_q;
  assign bus.bcd1      = bcd1_q;
  assign bus.bcd0      = bcd0_q;
  assign bus.overflow  = ovf_q;

endmodule
